ula_registrador_resultado: RTL
==============================

# ula_registrador_resultado

Registered result stage directly downstream of the 8-bit, 8-to-1 ALU result multiplexer. It captures the selected 8-bit result together with its 3-bit opcode and the adder's carry/overflow. It derives the status flags and buffers up to two results in a 2-entry FIFO. Results are presented to the display/consumer logic over a valid/ready handshake.

## Interface
- `DEPTH`, 2: FIFO entries. Fixed at 2; other values are not supported.
- `CV_MASK`, 8'b0000_0011: bit k set means opcode k propagates C/V; otherwise C=V=0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_result` in 8: output of the 8-to-1 result mux.
- `in_sel` in 3: opcode that drove the mux `sel` in the same cycle.
- `in_carry` in 1: adder/subtractor carry-out.
- `in_overflow` in 1: adder/subtractor signed overflow.
- `in_valid` in 1: upstream result is valid.
- `in_ready` out 1: a slot is free; a beat is accepted when `in_valid && in_ready`.
- `out_result` out 8: head-of-FIFO result.
- `out_sel` out 3: head-of-FIFO opcode.
- `out_flags` out 4: {Z, N, C, V} of the head entry.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: consumer accepts; a pop occurs when `out_valid && out_ready`.
- `op_count` out 8: number of accepted beats, modulo 256.

## Operation
- Flags are computed at push time and stored with the entry:
  - Z = (in_result == 8'h00).
  - N = in_result[7].
  - C = in_carry & CV_MASK[in_sel].
  - V = in_overflow & CV_MASK[in_sel].
- Storage is 2 entries of 15 bits (result 8, opcode 3, flags 4), with 1-bit read and write pointers and a 2-bit `count` in the range 0..2.
- Push: the entry is written at wr_ptr, wr_ptr toggles, and count increments.
- Pop: rd_ptr toggles and count decrements.
- Simultaneous push and pop with count=1: both occur and count stays 1. The new entry becomes head in the following cycle.
- Push attempt with count=2: `in_ready`=0, so the beat is not accepted and the upstream must hold it. Nothing is overwritten.
- Pop with count=0: impossible because `out_valid`=0. Pointers do not move.
- `in_ready` = (count != 2). It depends only on registered state, with no combinational path from `out_ready`.
- `out_valid` = (count != 0). `out_result`, `out_sel` and `out_flags` are read from the entry at rd_ptr. They are undefined-but-stable (zeros after reset) when `out_valid`=0.
- `op_count` increments by 1 on every accepted push and wraps 8'hFF→8'h00. Pops do not affect it.
- Reset (async assert, any time, including mid-transfer):
  - count, pointers, storage, and `op_count` are all cleared.
  - Outputs: `out_valid`=0, `out_result`=0, `out_sel`=0, `out_flags`=0, `op_count`=0, `in_ready`=1.
  - Any in-flight beat is dropped.

## Timing
- Latency: a beat accepted at edge n is visible with `out_valid`=1 after edge n, i.e. one cycle of latency.
- Throughput: 1 beat per cycle when `out_ready` is held high.
- After a pop from full (count=2→1), `in_ready` rises the cycle after that edge. There is no same-cycle pass-through.
- Reset deassertion is sampled by `clk`. The first push can occur on the first rising edge with `rst_n`=1.
- Upstream rule: once `in_valid` is asserted it must hold data stable until accepted.
- Downstream rule: outputs are stable while `out_valid && !out_ready`.

## Structure
- Shared package `ula_pkg`:
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_NOT=5, OP_SHL=6, OP_SHR=7.
  - Flag bit indices: FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - Entry struct/width constant (15 bits).
- Sub-module `ula_calc_flags`: combinational {Z, N, C, V} from result, opcode, carry, overflow, and `CV_MASK`. All storage and counters stay in the top module.

## Test plan
- **Reset values:** hold `rst_n`=0 mid-stream with 2 entries stored → `out_valid`=0, `in_ready`=1, `op_count`=0, all outputs 0; after release, push 8'h5A → head 8'h5A.
- **Flags:**
  - Push `in_result`=8'h00, `in_sel`=OP_ADD, carry=1, ovf=0 → flags 4'b1010.
  - Push 8'h80, OP_AND, carry=1, ovf=1 → flags 4'b0100 (C/V masked).
- **Full/backpressure:**
  - With `out_ready`=0, push 8'h11, 8'h22, then offer 8'h33 → 8'h33 is not accepted and `in_ready`=0.
  - Raise `out_ready` → pops 8'h11, then 8'h22; `in_ready` is 1 the cycle after the first pop, and 8'h33 is accepted afterwards.
- **Simultaneous push/pop:** with count=1 (head 8'hA0), push 8'hB0 while popping → count stays 1 and the next head is 8'hB0 with `out_sel` matching.
- **Streaming:** `out_ready`=1, push 0..9 on consecutive cycles → outputs 0..9 in order, one per cycle, one cycle delayed, with no bubbles.
- **Counter wrap:** 257 accepted pushes → `op_count`=8'h01; pops alone leave it unchanged.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU result stage: opcodes, flag positions, FIFO entry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int ENTRY_W = 15;

  // One buffered result: value, the opcode that produced it, and its {Z,N,C,V}.
  typedef struct packed {
    logic [7:0] result;
    logic [2:0] sel;
    logic [3:0] flags;
  } entry_t;

endpackage

// File: rtl/ula_calc_flags.sv
// Derives {Z,N,C,V} for one ALU result; C/V pass only for opcodes enabled in CV_MASK.
// Latency: purely combinational.
// Backpressure: none (no state).
module ula_calc_flags
  import ula_pkg::*;
#(
  parameter logic [7:0] CV_MASK = 8'b0000_0011
) (
  input  logic [7:0] result,
  input  logic [2:0] sel,
  input  logic       carry,
  input  logic       overflow,
  output logic [3:0] flags
);

  // Flag derivation; carry/overflow are meaningless for logic/shift opcodes.
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == 8'h00);
    flags[FLAG_N] = result[7];
    flags[FLAG_C] = carry & CV_MASK[sel];
    flags[FLAG_V] = overflow & CV_MASK[sel];
  end

endmodule

// File: rtl/ula_registrador_resultado.sv
// Registers the ALU mux result with opcode and flags into a 2-entry FIFO for the consumer.
// Latency: one cycle from accepted beat to out_valid.
// Backpressure: in_ready = not full, from registered state only; no pass-through when full.
module ula_registrador_resultado
  import ula_pkg::*;
#(
  parameter int         DEPTH   = 2,
  parameter logic [7:0] CV_MASK = 8'b0000_0011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_result,
  input  logic [2:0] in_sel,
  input  logic       in_carry,
  input  logic       in_overflow,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_result,
  output logic [2:0] out_sel,
  output logic [3:0] out_flags,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] op_count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [3:0] new_flags;
  logic       push;
  logic       pop;

  ula_calc_flags #(
    .CV_MASK (CV_MASK)
  ) u_calc_flags (
    .result   (in_result),
    .sel      (in_sel),
    .carry    (in_carry),
    .overflow (in_overflow),
    .flags    (new_flags)
  );

  assign in_ready   = (count != FULL);
  assign out_valid  = (count != 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_result = mem[rd_ptr].result;
  assign out_sel    = mem[rd_ptr].sel;
  assign out_flags  = mem[rd_ptr].flags;

  // Entry storage; cleared on reset so idle outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{result: in_result, sel: in_sel, flags: new_flags};
    end
  end

  // Pointers, occupancy and accepted-beat counter; push+pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      op_count <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr   <= ~wr_ptr;
        op_count <= op_count + 8'd1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
